// File: rtl/aes2_ctr_pkg.sv
// Shared types and constants for the AES-128 CTR-mode sequencer.
package aes2_ctr_pkg;

  localparam int AES_BLK_W       = 128;
  localparam int NBLK_W          = 16;
  localparam int CTR_W_DEF       = 32;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef logic [AES_BLK_W-1:0] blk_t;
  typedef logic [NBLK_W-1:0]    nblk_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DATA,
    S_OUT
  } state_t;

endpackage

// File: rtl/aes2_ctr_sched_if.sv
// Signal bundle between a parent/driver and the CTR sequencer: config, data streams, core port.
interface aes2_ctr_sched_if;
  import aes2_ctr_pkg::*;

  logic  cfg_start;
  blk_t  cfg_iv;
  blk_t  cfg_key;
  nblk_t cfg_nblk;
  logic  busy;
  logic  done;
  logic  err;

  logic  in_valid;
  logic  in_ready;
  blk_t  in_data;
  logic  out_valid;
  logic  out_ready;
  blk_t  out_data;

  logic  core_ld;
  blk_t  core_key;
  blk_t  core_text;
  logic  core_done;
  blk_t  core_text_out;

  modport slave (
    input  cfg_start, cfg_iv, cfg_key, cfg_nblk,
    input  in_valid, in_data, out_ready,
    input  core_done, core_text_out,
    output busy, done, err,
    output in_ready, out_valid, out_data,
    output core_ld, core_key, core_text
  );

  modport master (
    output cfg_start, cfg_iv, cfg_key, cfg_nblk,
    output in_valid, in_data, out_ready,
    output core_done, core_text_out,
    input  busy, done, err,
    input  in_ready, out_valid, out_data,
    input  core_ld, core_key, core_text
  );

endinterface

// File: rtl/aes2_ctr_inc.sv
// Counter-block incrementer: low CTR_W bits count modulo 2^CTR_W, upper bits pass through.
module aes2_ctr_inc
  import aes2_ctr_pkg::*;
#(
  parameter int CTR_W = CTR_W_DEF
) (
  input  blk_t ctr,
  output blk_t ctr_next
);

  if (CTR_W >= AES_BLK_W) begin : g_full
    assign ctr_next = ctr + AES_BLK_W'(1);
  end else begin : g_field
    // Carry out of the low field is discarded so the nonce part never changes.
    assign ctr_next = {ctr[AES_BLK_W-1:CTR_W], ctr[CTR_W-1:0] + CTR_W'(1)};
  end

endmodule

// File: rtl/aes2_ctr_sched.sv
// CTR-mode sequencer driving a shared AES-128 core via ld/done and XORing the keystream
// into a valid/ready data stream. Optional core watchdog: define AES2_CTR_TIMEOUT_EN.
module aes2_ctr_sched
  import aes2_ctr_pkg::*;
#(
  parameter int CTR_W       = CTR_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  aes2_ctr_sched_if.slave  bus
);

  if (CTR_W < 1 || CTR_W > AES_BLK_W || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("aes2_ctr_sched: CTR_W must be 1..128 and TIMEOUT_CYC at least 1");
  end

  state_t state;
  blk_t   ctr_q, key_q, ks_q, out_q, ctr_next;
  nblk_t  rem_q;
  logic   busy_q, done_q, err_q, in_ready_q, out_valid_q, core_ld_q;
  logic   wd_expire;

  aes2_ctr_inc #(.CTR_W(CTR_W)) u_inc (
    .ctr      (ctr_q),
    .ctr_next (ctr_next)
  );

`ifdef AES2_CTR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q;

  // Counts cycles spent in WAIT; expiry lands on the TIMEOUT_CYC-th WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 wd_q <= '0;
    else if (state == S_LOAD) wd_q <= '0;
    else if (state == S_WAIT) wd_q <= wd_q + WD_W'(1);
  end

  assign wd_expire = (wd_q == WD_W'(TIMEOUT_CYC - 1));
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: every register is reset, including the datapath, so a mid-job reset leaves nothing stale on the outputs.
      state       <= S_IDLE;
      ctr_q       <= '0;
      key_q       <= '0;
      ks_q        <= '0;
      out_q       <= '0;
      rem_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      core_ld_q   <= 1'b0;
    end else begin
      // NOTE: defaulting done low here and setting it in a branch yields a one-cycle pulse.
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cfg_start) begin
            ctr_q <= bus.cfg_iv;
            key_q <= bus.cfg_key;
            rem_q <= bus.cfg_nblk;
            err_q <= 1'b0;
            if (bus.cfg_nblk == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q    <= 1'b1;
              core_ld_q <= 1'b1;
              state     <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          core_ld_q <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.core_done) begin
            ks_q       <= bus.core_text_out;
            in_ready_q <= 1'b1;
            state      <= S_DATA;
          end else if (wd_expire) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        S_DATA: begin
          if (bus.in_valid) begin
            out_q       <= bus.in_data ^ ks_q;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (rem_q == NBLK_W'(1)) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= S_IDLE;
            end else begin
              rem_q     <= rem_q - NBLK_W'(1);
              ctr_q     <= ctr_next;
              core_ld_q <= 1'b1;
              state     <= S_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;
  assign bus.core_ld   = core_ld_q;
  assign bus.core_key  = key_q;
  assign bus.core_text = ctr_q;

endmodule

// File: tb/tb_aes2_ctr_sched.sv
// Directed bench for aes2_ctr_sched with a fixed-latency stand-in cipher core (ks = text ^ MASK).
module tb_aes2_ctr_sched;
  import aes2_ctr_pkg::*;

  localparam int   LC   = 10;
  localparam blk_t MASK = 128'h0123456789abcdef_0123456789abcdef;
  localparam blk_t KEY1 = 128'h2b7e151628aed2a6_abf7158809cf4f3c;
  localparam blk_t KEY2 = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk = 1'b0;
  logic rst;
  aes2_ctr_sched_if bus();

  aes2_ctr_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ld_cnt = 0;
  int done_cnt = 0;
  int done_time = 0;
  int bad_done = 0;
  int   ld_time [32];
  blk_t ld_text [32];

  logic core_hold = 1'b0;
  logic pending = 1'b0;
  int   age = 0;
  blk_t text_lat;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Stand-in core: done lands in the LC-th cycle after the ld cycle; it ignores rst on purpose.
  always @(negedge clk) begin
    bus.core_done = 1'b0;
    if (core_hold) begin
      pending = 1'b0;
    end else if (bus.core_ld === 1'b1) begin
      pending  = 1'b1;
      age      = 0;
      text_lat = bus.core_text;
    end else if (pending) begin
      age++;
      if (age == LC) begin
        bus.core_done     = 1'b1;
        bus.core_text_out = text_lat ^ MASK;
        pending           = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.core_ld === 1'b1 && ld_cnt < 32) begin
      ld_time[ld_cnt] = cyc;
      ld_text[ld_cnt] = bus.core_text;
      ld_cnt++;
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_time = cyc;
      if (bus.busy !== 1'b0) bad_done++;
    end
  end

  task automatic start_job(input blk_t iv, input blk_t key, input nblk_t n);
    bus.cfg_iv    = iv;
    bus.cfg_key   = key;
    bus.cfg_nblk  = n;
    bus.cfg_start = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
  endtask

  task automatic do_block(input string tag, input blk_t din, input blk_t exp, input int hold);
    int snap;
    bus.in_valid = 1'b1;
    bus.in_data  = din;
    for (int i = 0; i < 200; i++) begin
      if (bus.in_ready === 1'b1) break;
      @(negedge clk);
    end
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    check({tag, "_out_valid"}, bus.out_valid, 1'b1);
    check({tag, "_out_data"}, bus.out_data, exp);
    snap = ld_cnt;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, bus.out_valid, 1'b1);
      check({tag, "_hold_data"}, bus.out_data, exp);
      check({tag, "_hold_no_ld"}, 128'(ld_cnt), 128'(snap));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 500; i++) begin
      if (bus.busy === 1'b0) break;
      @(negedge clk);
    end
    check({tag, "_idle"}, bus.busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int ld0, dn0;
    rst           = 1'b0;
    bus.cfg_start = 1'b0;
    bus.cfg_iv    = '0;
    bus.cfg_key   = '0;
    bus.cfg_nblk  = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_core_ld", bus.core_ld, 1'b0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_core_text", bus.core_text, '0);
    check("rst_core_key", bus.core_key, '0);
    rst = 1'b1;
    @(negedge clk);

    // Three blocks from IV=0: counters 0,1,2, period LC+3, a single done.
    ld0 = ld_cnt; dn0 = done_cnt;
    start_job('0, KEY1, 16'd3);
    check("t1_busy", bus.busy, 1'b1);
    check("t1_core_key", bus.core_key, KEY1);
    do_block("t1_b0", 128'h0, 128'h0123456789abcdef_0123456789abcdef, 0);
    do_block("t1_b1", '1, 128'hfedcba9876543210_fedcba9876543211, 0);
    do_block("t1_b2", 128'h11111111111111111111111111111111,
             128'h1032547698badcfe_1032547698badcfc, 0);
    wait_idle("t1");
    check("t1_ld_count", 128'(ld_cnt - ld0), 128'd3);
    check("t1_text0", ld_text[ld0], 128'd0);
    check("t1_text1", ld_text[ld0+1], 128'd1);
    check("t1_text2", ld_text[ld0+2], 128'd2);
    check("t1_period01", 128'(ld_time[ld0+1] - ld_time[ld0]), 128'd13);
    check("t1_period12", 128'(ld_time[ld0+2] - ld_time[ld0+1]), 128'd13);
    check("t1_done_count", 128'(done_cnt - dn0), 128'd1);

    // Low 32-bit field wraps to zero, upper bits untouched.
    ld0 = ld_cnt;
    start_job({96'ha5a5a5a5_a5a5a5a5_a5a5a5a5, 32'hffffffff}, KEY1, 16'd2);
    do_block("t2_b0", {96'ha5a5a5a5_a5a5a5a5_a5a5a5a5, 32'hffffffff} ^ MASK, 128'h0, 0);
    do_block("t2_b1", MASK ^ 128'h1, 128'ha5a5a5a5_a5a5a5a5_a5a5a5a5_00000001, 0);
    wait_idle("t2");
    check("t2_text0", ld_text[ld0], 128'ha5a5a5a5_a5a5a5a5_a5a5a5a5_ffffffff);
    check("t2_text1", ld_text[ld0+1], 128'ha5a5a5a5_a5a5a5a5_a5a5a5a5_00000000);

    // Output back-pressure for 5 cycles holds data and blocks the next load.
    ld0 = ld_cnt;
    start_job(128'h10, KEY1, 16'd2);
    do_block("t3_b0", MASK, 128'h10, 5);
    do_block("t3_b1", 128'h0, 128'h0123456789abcdef_0123456789abcdfe, 0);
    wait_idle("t3");
    check("t3_ld_count", 128'(ld_cnt - ld0), 128'd2);

    // Zero-block job: done next cycle, never busy, no core load.
    ld0 = ld_cnt; dn0 = done_cnt;
    start_job(128'h5, KEY2, 16'd0);
    check("t4_done", bus.done, 1'b1);
    check("t4_busy", bus.busy, 1'b0);
    @(negedge clk);
    check("t4_done_drop", bus.done, 1'b0);
    check("t4_busy_after", bus.busy, 1'b0);
    check("t4_no_ld", 128'(ld_cnt - ld0), 128'd0);
    check("t4_done_count", 128'(done_cnt - dn0), 128'd1);

    // A start while busy is ignored.
    ld0 = ld_cnt; dn0 = done_cnt;
    start_job(128'h7, KEY2, 16'd1);
    repeat (2) @(negedge clk);
    bus.cfg_iv    = 128'haa;
    bus.cfg_key   = KEY1;
    bus.cfg_nblk  = 16'd5;
    bus.cfg_start = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    do_block("t5_b0", 128'h0, 128'h0123456789abcdef_0123456789abcde8, 0);
    wait_idle("t5");
    check("t5_ld_count", 128'(ld_cnt - ld0), 128'd1);
    check("t5_text", ld_text[ld0], 128'h7);
    check("t5_key", bus.core_key, KEY2);
    check("t5_done_count", 128'(done_cnt - dn0), 128'd1);
    check("t5_err", bus.err, 1'b0);

    // Reset during WAIT clears outputs; the late core result is dropped.
    ld0 = ld_cnt;
    start_job(128'h40, KEY1, 16'd2);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_busy", bus.busy, 1'b0);
    check("t6_core_text", bus.core_text, '0);
    check("t6_core_key", bus.core_key, '0);
    check("t6_out_data", bus.out_data, '0);
    check("t6_core_ld", bus.core_ld, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dn0 = done_cnt;
    repeat (15) @(negedge clk);
    check("t6_late_in_ready", bus.in_ready, 1'b0);
    check("t6_late_out_valid", bus.out_valid, 1'b0);
    check("t6_late_busy", bus.busy, 1'b0);
    check("t6_late_done", 128'(done_cnt - dn0), 128'd0);
    check("t6_ld_count", 128'(ld_cnt - ld0), 128'd1);

`ifdef AES2_CTR_TIMEOUT_EN
    // Core never answers: err and done after 64 WAIT cycles; next start clears err.
    ld0 = ld_cnt; dn0 = done_cnt;
    core_hold = 1'b1;
    start_job(128'h3, KEY1, 16'd1);
    for (int i = 0; i < 300; i++) begin
      if (done_cnt != dn0) break;
      @(negedge clk);
    end
    check("t7_done_count", 128'(done_cnt - dn0), 128'd1);
    check("t7_err", bus.err, 1'b1);
    check("t7_busy", bus.busy, 1'b0);
    check("t7_latency", 128'(done_time - ld_time[ld0]), 128'd65);
    core_hold = 1'b0;
    @(negedge clk);
    start_job(128'h0, KEY1, 16'd0);
    check("t7_err_clear", bus.err, 1'b0);
`endif

    check("done_with_busy", 128'(bad_done), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
